// File: rtl/fp_sum_normalizer.sv
// fp_sum_normalizer: renormalises the raw mantissa sum from the FP adder
// front end, one shift per clock, and re-packs sign/exponent/fraction.
// Truncating (no rounding); zero is flushed; overflow and underflow are flagged.
module fp_sum_normalizer #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [MAN_W+1:0] in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_frac,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_unf
);

   localparam int MW = MAN_W + 2;   // carry + hidden + fraction
   localparam int XW = EXP_W + 1;   // one spare bit so exp+1 / exp-1 never wrap
   localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t            state_reg, state_next;
   logic [MW-1:0]     mant_reg,  mant_next;
   logic [XW-1:0]     exp_reg,   exp_next;
   logic              sign_reg,  sign_next;

   // Packed result computed in NORM; loaded into the out_* registers on the
   // edge that enters DONE.
   logic              load_out;
   logic [EXP_W-1:0]  res_exp_next;
   logic [MAN_W-1:0]  res_frac_next;
   logic              res_zero_next, res_ovf_next, res_unf_next;

   logic [XW-1:0]     exp_inc, exp_dec;

   assign exp_inc = exp_reg + 1'b1;
   assign exp_dec = exp_reg - 1'b1;

   // State and working registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         mant_reg  <= '0;
         exp_reg   <= '0;
         sign_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         mant_reg  <= mant_next;
         exp_reg   <= exp_next;
         sign_reg  <= sign_next;
      end
   end

   // Next-state and normalisation step: one priority-ordered decision per NORM cycle.
   always_comb begin
      state_next    = state_reg;
      mant_next     = mant_reg;
      exp_next      = exp_reg;
      sign_next     = sign_reg;
      load_out      = 1'b0;
      res_exp_next  = '0;
      res_frac_next = '0;
      res_zero_next = 1'b0;
      res_ovf_next  = 1'b0;
      res_unf_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               sign_next  = in_sign;
               exp_next   = {1'b0, in_exp};
               mant_next  = in_mant;
               state_next = NORM;
            end
         end
         NORM: begin
            if (mant_reg == '0) begin
               // Exact cancellation: flush to zero.
               load_out      = 1'b1;
               res_zero_next = 1'b1;
               state_next    = DONE;
            end else if (mant_reg[MW-1]) begin
               // Carry out: one right shift (LSB dropped), exponent up.
               // An exponent already at the inf code also saturates here.
               load_out   = 1'b1;
               state_next = DONE;
               if (exp_inc >= EXP_MAX) begin
                  res_ovf_next = 1'b1;
                  res_exp_next = EXP_MAX[EXP_W-1:0];
               end else begin
                  res_exp_next  = exp_inc[EXP_W-1:0];
                  res_frac_next = mant_reg[MAN_W:1];
               end
            end else if (mant_reg[MAN_W]) begin
               // Hidden bit in place: already normalised.
               load_out      = 1'b1;
               res_exp_next  = exp_reg[EXP_W-1:0];
               res_frac_next = mant_reg[MAN_W-1:0];
               state_next    = DONE;
            end else if (exp_reg <= XW'(1)) begin
               // Another left shift would reach the zero exponent code.
               load_out     = 1'b1;
               res_unf_next = 1'b1;
               state_next   = DONE;
            end else begin
               mant_next = {mant_reg[MW-2:0], 1'b0};
               exp_next  = exp_dec;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state; nothing is accepted while in reset.
   always_comb begin
      in_ready  = rst_n && (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   // Result registers: cleared by reset, loaded on entry to DONE, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_sign <= 1'b0;
         out_exp  <= '0;
         out_frac <= '0;
         out_zero <= 1'b0;
         out_ovf  <= 1'b0;
         out_unf  <= 1'b0;
      end else if (load_out) begin
         out_sign <= sign_reg;
         out_exp  <= res_exp_next;
         out_frac <= res_frac_next;
         out_zero <= res_zero_next;
         out_ovf  <= res_ovf_next;
         out_unf  <= res_unf_next;
      end
   end

endmodule
